aes_dec_ctrl: RTL and testbench

AES_DEC_CTRL -- requirements
Module: aes_dec_ctrl

---
 rtl/aes_dec_ctrl.sv | 126 ++++++++++++
 tb/tb_aes_dec_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_ctrl.sv
// rtl/aes_dec_ctrl.sv - AES-128 inverse-cipher sequencer driving external AddRoundKey/ShiftRows/SubBytes/MixColumns units
module aes_dec_ctrl #(
   parameter int STEP_TIMEOUT = 64
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         Start,
   input  logic [127:0] Cipher_Text,
   output logic [3:0]   Key_Sel,
   output logic [127:0] State_Text,
   output logic         Add_En,
   output logic         Shift_En,
   output logic         Sub_En,
   output logic         Mix_En,
   input  logic         Add_Ry,
   input  logic         Shift_Ry,
   input  logic         Sub_Ry,
   input  logic         Mix_Ry,
   input  logic [127:0] Add_Text,
   input  logic [127:0] Shift_Text,
   input  logic [127:0] Sub_Text,
   input  logic [127:0] Mix_Text,
   output logic [127:0] Plain_Text,
   output logic         Busy,
   output logic         Done,
   output logic         Error
);
   localparam int CW = $clog2(STEP_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, ADD, SHIFT, SUB, MIX, FIN} state_t;

   state_t         state, state_nxt;
   logic [3:0]     round, round_nxt;
   logic [CW-1:0]  wait_cnt;
   logic           step, sel_ry, go, tmo, accept;
   logic [127:0]   sel_text;

   assign Key_Sel  = round;
   assign Add_En   = (state == ADD);
   assign Shift_En = (state == SHIFT);
   assign Sub_En   = (state == SUB);
   assign Mix_En   = (state == MIX);

   assign step   = Add_En | Shift_En | Sub_En | Mix_En;
   // wait_cnt is zero only in the entry cycle of a step, so ready is ignored there
   assign go     = step && (wait_cnt != '0) && sel_ry;
   assign tmo    = step && !go && (wait_cnt == CW'(STEP_TIMEOUT - 1));
   // Done still high means the previous block just finished: a Start here is not a fresh request
   assign accept = (state == IDLE) && Start && !Done;

   always_comb begin
      sel_ry   = 1'b0;
      sel_text = State_Text;
      case (state)
         ADD:     begin sel_ry = Add_Ry;   sel_text = Add_Text;   end
         SHIFT:   begin sel_ry = Shift_Ry; sel_text = Shift_Text; end
         SUB:     begin sel_ry = Sub_Ry;   sel_text = Sub_Text;   end
         MIX:     begin sel_ry = Mix_Ry;   sel_text = Mix_Text;   end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      round_nxt = round;
      case (state)
         IDLE: if (accept) begin
            state_nxt = ADD;
            round_nxt = 4'd10;
         end
         ADD: if (go) begin
            if (round == 4'd10) begin
               state_nxt = SHIFT;
               round_nxt = 4'd9;
            end else if (round == 4'd0) begin
               state_nxt = FIN;
            end else begin
               state_nxt = MIX;
            end
         end
         SHIFT: if (go) state_nxt = SUB;
         SUB:   if (go) state_nxt = ADD;
         MIX: if (go) begin
            state_nxt = SHIFT;
            round_nxt = round - 4'd1;
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (tmo) state_nxt = IDLE;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state      <= IDLE;
         round      <= '0;
         wait_cnt   <= '0;
         State_Text <= '0;
         Plain_Text <= '0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
         Error      <= 1'b0;
      end else begin
         state <= state_nxt;
         round <= round_nxt;
         Done  <= 1'b0;
         Error <= 1'b0;
         if (!step || go || tmo) wait_cnt <= '0;
         else                    wait_cnt <= wait_cnt + CW'(1);
         if (accept) begin
            State_Text <= Cipher_Text;
            Busy       <= 1'b1;
         end
         if (go) State_Text <= sel_text;
         if (tmo) begin
            Error <= 1'b1;
            Busy  <= 1'b0;
         end
         if (state == FIN) begin
            Plain_Text <= State_Text;
            Done       <= 1'b1;
            Busy       <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_aes_dec_ctrl.sv
// tb/tb_aes_dec_ctrl.sv - scoreboard bench for aes_dec_ctrl with behavioural inverse-AES units
module tb_aes_dec_ctrl;
   localparam int TMO = 64;
   localparam logic [127:0] KEY     = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

   logic         Clk = 1'b0;
   logic         Rst, Start;
   logic [127:0] Cipher_Text, State_Text, Plain_Text;
   logic [3:0]   Key_Sel;
   logic         Add_En, Shift_En, Sub_En, Mix_En;
   logic         Add_Ry, Shift_Ry, Sub_Ry, Mix_Ry;
   logic [127:0] Add_Text, Shift_Text, Sub_Text, Mix_Text;
   logic         Busy, Done, Error;

   typedef struct {
      int           kind;
      logic [127:0] pt;
      int           lat;
      int           t0;
   } exp_t;

   exp_t         exp_q[$];
   int           tr_q[$], key_q[$], exp_tr[$], exp_key[$];
   int           checks = 0, errors = 0, cyc = 0, ev_cnt = 0;
   int           dly[4] = '{1, 1, 1, 1};
   int           ucnt[4] = '{0, 0, 0, 0};
   logic         stray = 1'b0, hang_mix = 1'b0;
   logic [127:0] last_pt = '0;
   logic [7:0]   sbox[256], isbox[256];
   logic [127:0] rk[11];
   logic [3:0]   en_v, prev_en = 4'b0;
   logic [127:0] prev_st = '0;

   aes_dec_ctrl #(.STEP_TIMEOUT(TMO)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Cipher_Text(Cipher_Text),
      .Key_Sel(Key_Sel), .State_Text(State_Text),
      .Add_En(Add_En), .Shift_En(Shift_En), .Sub_En(Sub_En), .Mix_En(Mix_En),
      .Add_Ry(Add_Ry), .Shift_Ry(Shift_Ry), .Sub_Ry(Sub_Ry), .Mix_Ry(Mix_Ry),
      .Add_Text(Add_Text), .Shift_Text(Shift_Text), .Sub_Text(Sub_Text), .Mix_Text(Mix_Text),
      .Plain_Text(Plain_Text), .Busy(Busy), .Done(Done), .Error(Error)
   );

   always #5 Clk = ~Clk;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xt(x);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] gb(input logic [127:0] s, input int i);
      return s[127 - 8*i -: 8];
   endfunction

   function automatic logic [127:0] inv_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8*(r + 4*c) -: 8] = gb(s, r + 4*((c - r + 4) % 4));
      return o;
   endfunction

   function automatic logic [127:0] inv_sub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = isbox[gb(s, i)];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
         o[127 - 32*c -: 32] = {gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09),
                                gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d),
                                gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b),
                                gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e)};
      end
      return o;
   endfunction

   function automatic logic [127:0] rk_at(input logic [3:0] k);
      return (k <= 4'd10) ? rk[int'(k)] : '0;
   endfunction

   // FIPS-197 inverse cipher, used as the reference for every successful block
   function automatic logic [127:0] inv_cipher(input logic [127:0] ct);
      logic [127:0] s;
      s = ct ^ rk[10];
      for (int r = 9; r >= 1; r--) s = inv_mix(inv_sub(inv_shift(s)) ^ rk[r]);
      return inv_sub(inv_shift(s)) ^ rk[0];
   endfunction

   function automatic int lat_model();
      return 11*(dly[0]+1) + 10*(dly[1]+1) + 10*(dly[2]+1) + 9*(dly[3]+1) + 1;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic int trace_diff();
      int d;
      d = 0;
      if (tr_q.size() != exp_tr.size() || key_q.size() != exp_key.size()) return 1000;
      foreach (tr_q[i]) if (tr_q[i] != exp_tr[i]) d++;
      foreach (key_q[i]) if (key_q[i] != exp_key[i]) d++;
      return d;
   endfunction

   task automatic build_tables();
      logic [7:0]  inv, b, rc;
      logic [31:0] w[44];
      logic [31:0] t;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
         sbox[x] = b;
         isbox[b] = 8'(x);
      end
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = KEY[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      exp_tr.push_back(0);
      for (int r = 9; r >= 1; r--) begin
         exp_tr.push_back(1); exp_tr.push_back(2); exp_tr.push_back(0); exp_tr.push_back(3);
      end
      exp_tr.push_back(1); exp_tr.push_back(2); exp_tr.push_back(0);
      for (int k = 10; k >= 0; k--) exp_key.push_back(k);
   endtask

   task automatic check_v(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic check_i(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic check_rst(input string tag);
      check_i({tag, "_key_sel"}, int'(Key_Sel), 0);
      check_v({tag, "_state_text"}, State_Text, '0);
      check_v({tag, "_plain_text"}, Plain_Text, '0);
      check_i({tag, "_enables"}, int'(en_v), 0);
      check_i({tag, "_busy"}, int'(Busy), 0);
      check_i({tag, "_done"}, int'(Done), 0);
      check_i({tag, "_error"}, int'(Error), 0);
   endtask

   task automatic start_block(input logic [127:0] ct, input int kind, input logic [127:0] pt, input int lat);
      exp_t e;
      @(negedge Clk);
      Cipher_Text = ct;
      Start = 1'b1;
      @(posedge Clk);
      #1;
      e.kind = kind; e.pt = pt; e.lat = lat; e.t0 = cyc;
      exp_q.push_back(e);
      Start = 1'b0;
      Cipher_Text = rand128();
      check_i("busy_after_start", int'(Busy), 1);
      if (kind == 0) last_pt = pt;
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(negedge Clk);
         n++;
      end
      check_i("response_within_bound", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(negedge Clk);
   endtask

   // Behavioural units: ready dly cycles after enable rises; stray ready on idle units
   assign en_v       = {Mix_En, Sub_En, Shift_En, Add_En};
   assign Add_Ry     = Add_En   ? (ucnt[0] >= dly[0]) : stray;
   assign Shift_Ry   = Shift_En ? (ucnt[1] >= dly[1]) : stray;
   assign Sub_Ry     = Sub_En   ? (ucnt[2] >= dly[2]) : stray;
   assign Mix_Ry     = Mix_En   ? (!hang_mix && ucnt[3] >= dly[3]) : stray;
   assign Add_Text   = State_Text ^ rk_at(Key_Sel);
   assign Shift_Text = inv_shift(State_Text);
   assign Sub_Text   = inv_sub(State_Text);
   assign Mix_Text   = inv_mix(State_Text);

   always @(posedge Clk) begin
      cyc <= cyc + 1;
      for (int u = 0; u < 4; u++) ucnt[u] <= en_v[u] ? ucnt[u] + 1 : 0;
   end

   always @(negedge Clk) begin : monitor
      exp_t e;
      int   nmix;
      if (!Rst) begin
         check_i("enable_onehot0", $countones(en_v) <= 1 ? 1 : 0, 1);
         if ((en_v & prev_en) != 4'b0) check_v("hold_until_ready", State_Text, prev_st);
         for (int u = 0; u < 4; u++)
            if (en_v[u] && !prev_en[u]) begin
               tr_q.push_back(u);
               if (u == 0) key_q.push_back(int'(Key_Sel));
            end
         if (Done || Error) begin
            ev_cnt++;
            if (exp_q.size() == 0) begin
               check_i("unexpected_event", int'({Done, Error}), 0);
            end else begin
               e = exp_q.pop_front();
               check_i("event_kind", int'(Error), (e.kind == 1) ? 1 : 0);
               check_i("done_and_error", int'(Done & Error), 0);
               check_v("plain_text", Plain_Text, e.pt);
               check_i("latency", cyc - e.t0, e.lat);
               check_i("busy_cleared", int'(Busy), 0);
               if (Done) begin
                  check_i("trace_order", trace_diff(), 0);
                  nmix = 0;
                  foreach (tr_q[i]) if (tr_q[i] == 3) nmix++;
                  check_i("mix_steps", nmix, 9);
               end
            end
            tr_q.delete();
            key_q.delete();
         end
      end
      prev_en <= en_v;
      prev_st <= State_Text;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] ct, pt;
      int           n, ev0;
      Rst = 1'b1;
      Start = 1'b0;
      Cipher_Text = '0;
      build_tables();
      check_v("model_fips", inv_cipher(FIPS_CT), FIPS_PT);
      repeat (3) @(posedge Clk);
      #1;
      check_rst("reset");
      @(negedge Clk);
      Rst = 1'b0;
      repeat (5) @(negedge Clk);
      check_i("no_event_after_reset", ev_cnt, 0);

      start_block(FIPS_CT, 0, FIPS_PT, 81);
      wait_idle(300);

      dly[2] = 5;
      start_block(FIPS_CT, 0, FIPS_PT, 121);
      wait_idle(300);

      for (int k = 0; k < 6; k++) begin
         foreach (dly[i]) dly[i] = $urandom_range(1, 4);
         stray = 1'($urandom_range(0, 1));
         ct = rand128();
         start_block(ct, 0, inv_cipher(ct), lat_model());
         wait_idle(600);
      end
      foreach (dly[i]) dly[i] = 1;
      stray = 1'b0;

      hang_mix = 1'b1;
      pt = last_pt;
      start_block(rand128(), 1, pt, 2*(dly[0]+1) + (dly[1]+1) + (dly[2]+1) + TMO);
      wait_idle(300);
      hang_mix = 1'b0;
      check_v("error_keeps_plain", Plain_Text, pt);
      check_i("busy_after_error", int'(Busy), 0);
      ct = rand128();
      start_block(ct, 0, inv_cipher(ct), 81);
      wait_idle(300);

      start_block(FIPS_CT, 0, FIPS_PT, 81);
      n = 0;
      while (!(Mix_En && Key_Sel == 4'd5) && n < 300) begin
         @(negedge Clk);
         n++;
      end
      check_i("reached_round5", int'(Mix_En && Key_Sel == 4'd5), 1);
      #2 Rst = 1'b1;
      #1;
      check_rst("rst_mid");
      exp_q.delete();
      tr_q.delete();
      key_q.delete();
      last_pt = '0;
      @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      ev0 = ev_cnt;
      repeat (100) @(negedge Clk);
      check_i("quiet_after_reset", ev_cnt - ev0, 0);
      ct = rand128();
      start_block(ct, 0, inv_cipher(ct), 81);
      wait_idle(300);

      ct = rand128();
      pt = inv_cipher(ct);
      start_block(ct, 0, pt, 81);
      repeat (30) @(negedge Clk);
      Start = 1'b1;
      Cipher_Text = rand128();
      @(negedge Clk);
      Start = 1'b0;
      n = 0;
      while (!Done && n < 200) begin
         @(negedge Clk);
         n++;
      end
      check_i("done_seen", int'(Done), 1);
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      ev0 = ev_cnt;
      repeat (120) @(negedge Clk);
      check_i("single_done", ev_cnt - ev0, 0);
      check_i("busy_idle", int'(Busy), 0);
      check_v("first_result_kept", Plain_Text, pt);
      check_i("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
